mdu_seq: RTL and testbench
==========================

MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset. Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
REQ-002 Remaining ports SHALL be:
- start  input  1  EX-stage mult/div request (decoder mdToHilo); level, held while stalled.
- mulOrdiv  input  1  1=multiply, 0=divide.
- mdIsSign  input  1  1=signed, 0=unsigned.
- opa  input  32  rs operand (dividend / multiplicand).
- opb  input  32  rt operand (divisor / multiplier).
- flush  input  1  pipeline flush (exception); cancels operation.
- stall  output  1  freeze IF/ID/EX while operation is pending.
- done  output  1  one-cycle pulse; hi_out/lo_out valid, consumer writes HILO.
- hi_out  output  32  HI result (product[63:32] / remainder).
- lo_out  output  32  LO result (product[31:0] / quotient).

Function
REQ-003 FSM SHALL have four states: IDLE, MUL, DIV, DONE.
REQ-004 IDLE: start=1 and flush=0 SHALL accept the request; opa, opb, mulOrdiv and mdIsSign latch at the edge; next state is MUL if mulOrdiv=1, else DIV.
REQ-005 stall SHALL be combinational: (IDLE & start & ~flush) | MUL | DIV; stall=0 in DONE and during rst.
REQ-006 MUL SHALL last exactly one cycle: a 64-bit product is registered (signed or unsigned per the latched mdIsSign), then next state is DONE.
REQ-007 DIV SHALL be a radix-2 restoring divider on absolute values: a 5-bit counter runs 0..31, one quotient bit per cycle, and DIV->DONE occurs at the edge where count=31; DIV lasts exactly 32 cycles.
REQ-008 Signed divide correction SHALL be applied on entry to DONE: quotient negated if sign(opa)^sign(opb), remainder negated if sign(opa); results are modulo 2^32.
REQ-009 Divide by zero (opb=0) SHALL produce hi_out=opa and lo_out=0xFFFFFFFF for both signed and unsigned, with no exception and the same 32-cycle latency.
REQ-010 DONE SHALL last one cycle with done=1, then unconditionally return to IDLE; start seen while in DONE SHALL be ignored.
REQ-011 Latency, with the accept cycle = cycle 0: multiply done=1 in cycle 2 (stall high cycles 0-1); divide done=1 in cycle 33 (stall high cycles 0-32).
REQ-012 hi_out/lo_out SHALL change only on entry to DONE and hold their value otherwise.
REQ-013 flush=1 in any state SHALL force IDLE at the next edge with no done pulse and hi_out/lo_out unchanged; flush has priority over start.
REQ-014 In DONE, flush SHALL NOT suppress the done pulse already asserted; the next state is IDLE.
REQ-015 A new start SHALL be accepted in the first IDLE cycle after DONE or after a flush.

Reset
REQ-016 rst=1 SHALL force state=IDLE, counter=0, done=0, hi_out=0, lo_out=0, and clear the internal operand and remainder registers; rst has priority over flush and start.
REQ-017 rst asserted mid-operation SHALL abort the operation with no done pulse; outputs equal their reset values in the cycle after the edge.

Verification
REQ-018 Multiply: mult opa=0xFFFFFFFF, opb=2 -> done in cycle 2, hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE; stall high exactly cycles 0-1.
REQ-019 Signed divide: div opa=0xFFFFFFF9 (-7), opb=2 -> done in cycle 33, lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu with the same operands -> lo=0x7FFFFFFC, hi=0x00000001.
REQ-020 Overflow and divide by zero: div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; div 0x12345678 / 0 -> hi=0x12345678, lo=0xFFFFFFFF.
REQ-021 Flush: flush=1 in cycle 10 of a divide -> stall=0 from cycle 11, no done pulse, hi/lo retain the previous result; the following multiply is accepted and completes normally.
REQ-022 Reset: rst=1 in cycle 20 of a divide -> IDLE, hi=lo=0, done never pulses; with start held across DONE, no second operation starts.

Source files
------------

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit for the EX stage: one-cycle 32x32 multiply,
// 32-cycle radix-2 restoring divide, with flush cancel and HI/LO result registers.
module mdu_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        mulOrdiv,
   input  logic        mdIsSign,
   input  logic [31:0] opa,
   input  logic [31:0] opb,
   input  logic        flush,
   output logic        stall,
   output logic        done,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        sign_q, sign_d;
   logic [31:0] opa_q, opa_d;
   logic [31:0] opb_q, opb_d;
   logic [31:0] quot_q, quot_d;   // |dividend| shifts out of the top, quotient bits shift in
   logic [31:0] rem_q, rem_d;
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        accept;
   logic        neg_a, neg_b;
   logic [63:0] mul_a, mul_b, product;
   logic [32:0] rem_shift, trial;
   logic [31:0] quot_next, rem_next;
   logic [31:0] quot_fix, rem_fix;

   assign accept = (state_q == S_IDLE) && start && !flush;
   assign stall  = !rst && (accept || (state_q == S_MUL) || (state_q == S_DIV));
   assign done   = (state_q == S_DONE);
   assign hi_out = hi_q;
   assign lo_out = lo_q;

   assign neg_a   = sign_q & opa_q[31];
   assign neg_b   = sign_q & opb_q[31];
   assign mul_a   = {{32{neg_a}}, opa_q};
   assign mul_b   = {{32{neg_b}}, opb_q};
   assign product = mul_a * mul_b;

   // A set bit 32 of the trial difference is the borrow: the divisor did not fit.
   assign rem_shift = {rem_q, quot_q[31]};
   assign trial     = rem_shift - {1'b0, dvs_q};
   assign rem_next  = trial[32] ? rem_shift[31:0] : trial[31:0];
   assign quot_next = {quot_q[30:0], ~trial[32]};
   assign quot_fix  = (neg_a ^ neg_b) ? (32'd0 - quot_next) : quot_next;
   assign rem_fix   = neg_a ? (32'd0 - rem_next) : rem_next;

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
      state_d = state_q;
      cnt_d   = cnt_q;
      sign_d  = sign_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               opa_d   = opa;
               opb_d   = opb;
               sign_d  = mdIsSign;
               quot_d  = (mdIsSign && opa[31]) ? (32'd0 - opa) : opa;
               dvs_d   = (mdIsSign && opb[31]) ? (32'd0 - opb) : opb;
               rem_d   = 32'd0;
               cnt_d   = 5'd0;
               state_d = mulOrdiv ? S_MUL : S_DIV;
            end
         end
         S_MUL: begin
            hi_d    = product[63:32];
            lo_d    = product[31:0];
            state_d = S_DONE;
         end
         S_DIV: begin
            quot_d = quot_next;
            rem_d  = rem_next;
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = S_DONE;
               if (opb_q == 32'd0) begin
                  hi_d = opa_q;
                  lo_d = 32'hFFFF_FFFF;
               end else begin
                  hi_d = rem_fix;
                  lo_d = quot_fix;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A flush cancels whatever is in flight and leaves the visible results untouched.
      if (flush) begin
         state_d = S_IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 5'd0;
         sign_q  <= 1'b0;
         opa_q   <= 32'd0;
         opb_q   <= 32'd0;
         quot_q  <= 32'd0;
         rem_q   <= 32'd0;
         dvs_q   <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         // NOTE: registers use non-blocking assignment so all of them update together at the edge.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sign_q  <= sign_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: table of mult/div vectors with hand-computed
// results and latencies, plus hand-written flush and reset sequences.
module tb_mdu_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic        mulOrdiv;
   logic        mdIsSign;
   logic [31:0] opa;
   logic [31:0] opb;
   logic        flush;
   logic        stall;
   logic        done;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   int errors = 0;
   int checks = 0;
   logic [31:0] last_hi, last_lo;

   typedef struct {
      string       name;
      logic        mul;
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          lat;
   } vec_t;

   vec_t vecs[11];

   mdu_seq dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .mulOrdiv (mulOrdiv),
      .mdIsSign (mdIsSign),
      .opa      (opa),
      .opb      (opb),
      .flush    (flush),
      .stall    (stall),
      .done     (done),
      .hi_out   (hi_out),
      .lo_out   (lo_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation, hold start through DONE, then drop it in the following IDLE cycle.
   task automatic run_vec(input vec_t v);
      int          done_cyc;
      logic        stall_ok, hold_ok;
      logic [31:0] prev_hi, prev_lo;
      prev_hi  = hi_out;
      prev_lo  = lo_out;
      done_cyc = -1;
      stall_ok = 1'b1;
      hold_ok  = 1'b1;
      mulOrdiv = v.mul;
      mdIsSign = v.sgn;
      opa      = v.a;
      opb      = v.b;
      start    = 1'b1;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (done) begin
            done_cyc = c;
            if (stall) stall_ok = 1'b0;
            break;
         end
         if (!stall) stall_ok = 1'b0;
         if (hi_out !== prev_hi || lo_out !== prev_lo) hold_ok = 1'b0;
         next_cycle();
         opa = ~v.a;
         opb = ~v.b;
      end
      check({v.name, "_latency"}, done_cyc, v.lat);
      check({v.name, "_stall"}, {31'd0, stall_ok}, 32'd1);
      check({v.name, "_hold"}, {31'd0, hold_ok}, 32'd1);
      check({v.name, "_hi"}, hi_out, v.exp_hi);
      check({v.name, "_lo"}, lo_out, v.exp_lo);
      next_cycle();
      start = 1'b0;
      #1;
      check({v.name, "_idle_after"}, {30'd0, stall, done}, 32'd0);
      last_hi = v.exp_hi;
      last_lo = v.exp_lo;
   endtask

   initial begin
      logic no_done, held;

      vecs[0]  = '{"mult_m1x2",    1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};
      vecs[1]  = '{"multu_ffx2",   1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 2};
      vecs[2]  = '{"div_m7_2",     1'b0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
      vecs[3]  = '{"divu_m7_2",    1'b0, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, 33};
      vecs[4]  = '{"div_ovf",      1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33};
      vecs[5]  = '{"div_by0",      1'b0, 1'b1, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 33};
      vecs[6]  = '{"divu_by0",     1'b0, 1'b0, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 33};
      vecs[7]  = '{"mult_shift16", 1'b1, 1'b1, 32'h0001_2345, 32'h0001_0000, 32'h0000_0001, 32'h2345_0000, 2};
      vecs[8]  = '{"div_100_m7",   1'b0, 1'b1, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 33};
      vecs[9]  = '{"mult_min_max", 1'b1, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, 32'h8000_0000, 2};
      vecs[10] = '{"divu_ff_16",   1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 33};

      rst      = 1'b1;
      start    = 1'b1;
      flush    = 1'b0;
      mulOrdiv = 1'b1;
      mdIsSign = 1'b0;
      opa      = 32'hDEAD_BEEF;
      opb      = 32'h0000_0003;
      repeat (2) @(posedge clk);
      #1;
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_hi", hi_out, 32'd0);
      check("rst_lo", lo_out, 32'd0);
      rst   = 1'b0;
      start = 1'b0;
      last_hi = 32'd0;
      last_lo = 32'd0;

      // Back-to-back vectors: each new start lands in the first IDLE cycle after DONE.
      for (int i = 0; i < 11; i++) run_vec(vecs[i]);

      // Flush together with start in IDLE: request is not accepted.
      next_cycle();
      mulOrdiv = 1'b0; mdIsSign = 1'b0; opa = 32'd100; opb = 32'd7;
      start = 1'b1; flush = 1'b1;
      #1;
      check("flush_at_accept_stall", {31'd0, stall}, 32'd0);
      next_cycle();
      start = 1'b0; flush = 1'b0;
      #1;
      check("flush_at_accept_idle", {31'd0, stall}, 32'd0);

      // Flush in cycle 10 of a divide.
      next_cycle();
      start = 1'b1;
      repeat (10) next_cycle();
      flush = 1'b1;
      #1;
      check("flush_c10_stall", {31'd0, stall}, 32'd1);
      next_cycle();
      flush = 1'b0; start = 1'b0;
      #1;
      check("flush_c11_stall", {31'd0, stall}, 32'd0);
      no_done = 1'b1; held = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (done) no_done = 1'b0;
         if (hi_out !== last_hi || lo_out !== last_lo) held = 1'b0;
         next_cycle();
      end
      check("flush_div_no_done", {31'd0, no_done}, 32'd1);
      check("flush_div_hold", {31'd0, held}, 32'd1);
      run_vec(vecs[0]);

      // Flush during the single MUL cycle.
      next_cycle();
      mulOrdiv = 1'b1; mdIsSign = 1'b0; opa = 32'd5; opb = 32'd6; start = 1'b1;
      next_cycle();
      flush = 1'b1;
      next_cycle();
      flush = 1'b0; start = 1'b0;
      #1;
      check("flush_mul_done", {31'd0, done}, 32'd0);
      check("flush_mul_hi", hi_out, last_hi);
      check("flush_mul_lo", lo_out, last_lo);

      // Reset in cycle 20 of a divide.
      next_cycle();
      mulOrdiv = 1'b0; mdIsSign = 1'b1; opa = 32'd1000; opb = 32'd3; start = 1'b1;
      repeat (20) next_cycle();
      rst = 1'b1;
      #1;
      check("rst_c20_stall", {31'd0, stall}, 32'd0);
      next_cycle();
      rst = 1'b0; start = 1'b0;
      #1;
      check("rst_mid_hi", hi_out, 32'd0);
      check("rst_mid_lo", lo_out, 32'd0);
      check("rst_mid_done_stall", {30'd0, stall, done}, 32'd0);
      no_done = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (done) no_done = 1'b0;
         next_cycle();
      end
      check("rst_mid_no_done", {31'd0, no_done}, 32'd1);
      run_vec(vecs[3]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
